// File: rtl/instruction_dispatcher_pkg.sv
// Shared types and field widths for the instruction dispatcher.
// Provides the instruction field layout and the dispatch FSM state encoding.
package instruction_dispatcher_pkg;

   localparam int DISP_OP_W    = 3;
   localparam int DISP_DIM_W   = 7;
   localparam int DISP_ADDR_W  = 12;
   localparam int DISP_INSTR_W = DISP_OP_W + 6 * DISP_DIM_W + 2 * DISP_ADDR_W;

   localparam logic [DISP_OP_W-1:0] OP_NOP = 3'd0;

   // Field order is MSB to LSB.
   typedef struct packed {
      logic [DISP_OP_W-1:0]   op;
      logic [DISP_DIM_W-1:0]  v_dim;
      logic [DISP_DIM_W-1:0]  u_dim;
      logic [DISP_DIM_W-1:0]  iter_dim;
      logic [DISP_DIM_W-1:0]  v_dim1;
      logic [DISP_DIM_W-1:0]  u_dim1;
      logic [DISP_DIM_W-1:0]  iter_dim1;
      logic [DISP_ADDR_W-1:0] addr_rd;
      logic [DISP_ADDR_W-1:0] addr_wr;
   } instr_fields_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2
   } disp_state_t;

endpackage

// File: rtl/instruction_dispatcher_if.sv
// Host-side and control_unit-side signals of the instruction dispatcher.
// The master drives instructions and done; the slave (dispatcher) drives status and decoded fields.
interface instruction_dispatcher_if #(
   parameter int DEPTH  = 8,
   parameter int OP_W   = 3,
   parameter int DIM_W  = 7,
   parameter int ADDR_W = 12
);
   import instruction_dispatcher_pkg::*;

   localparam int INSTR_W = OP_W + 6 * DIM_W + 2 * ADDR_W;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   logic [INSTR_W-1:0] instruction_i;
   logic               write_i;
   logic               flush_i;
   logic               done_i;

   logic               iq_full_o;
   logic               overflow_o;
   logic [CNT_W-1:0]   count_o;
   logic               start_o;
   logic               busy_o;
   logic               idle_o;
   logic [OP_W-1:0]    MAC_op_o;
   logic [DIM_W-1:0]   V_dim_o;
   logic [DIM_W-1:0]   U_dim_o;
   logic [DIM_W-1:0]   ITER_dim_o;
   logic [DIM_W-1:0]   V_dim1_o;
   logic [DIM_W-1:0]   U_dim1_o;
   logic [DIM_W-1:0]   ITER_dim1_o;
   logic [ADDR_W-1:0]  ub_addr_start_rd_o;
   logic [ADDR_W-1:0]  ub_addr_start_wr_o;
   disp_state_t        state_o;

   modport master (
      output instruction_i, write_i, flush_i, done_i,
      input  iq_full_o, overflow_o, count_o, start_o, busy_o, idle_o,
      input  MAC_op_o, V_dim_o, U_dim_o, ITER_dim_o, V_dim1_o, U_dim1_o, ITER_dim1_o,
      input  ub_addr_start_rd_o, ub_addr_start_wr_o, state_o
   );

   modport slave (
      input  instruction_i, write_i, flush_i, done_i,
      output iq_full_o, overflow_o, count_o, start_o, busy_o, idle_o,
      output MAC_op_o, V_dim_o, U_dim_o, ITER_dim_o, V_dim1_o, U_dim1_o, ITER_dim1_o,
      output ub_addr_start_rd_o, ub_addr_start_wr_o, state_o
   );

endinterface

// File: rtl/instruction_dispatcher_fifo.sv
// DEPTH x W instruction FIFO with extra-MSB pointers, flush and a registered occupancy count.
// The head entry is presented combinationally on dout_o.
module dispatch_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 69
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [W-1:0]             din_i,
   output logic [W-1:0]             dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]  count_q, count_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push, do_pop;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
   assign count_o = count_q;

   // Flush wins over both push and pop in the same cycle.
   assign do_push = push_i && !full_o  && !flush_i;
   assign do_pop  = pop_i  && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
         if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/instruction_dispatcher.sv
// Queues host instructions, skips NOPs and issues one decoded instruction at a time to control_unit.
// Decoded fields are registered on each non-NOP pop and held until the next one.
module instruction_dispatcher
   import instruction_dispatcher_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int OP_W   = DISP_OP_W,
   parameter int DIM_W  = DISP_DIM_W,
   parameter int ADDR_W = DISP_ADDR_W
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   instruction_dispatcher_if.slave  bus
);

   localparam int INSTR_W = OP_W + 6 * DIM_W + 2 * ADDR_W;
   localparam int CNT_W   = $clog2(DEPTH) + 1;

   localparam int OFS_WR  = 0;
   localparam int OFS_RD  = ADDR_W;
   localparam int OFS_IT1 = 2 * ADDR_W;
   localparam int OFS_U1  = OFS_IT1 + DIM_W;
   localparam int OFS_V1  = OFS_U1 + DIM_W;
   localparam int OFS_IT  = OFS_V1 + DIM_W;
   localparam int OFS_U   = OFS_IT + DIM_W;
   localparam int OFS_V   = OFS_U + DIM_W;
   localparam int OFS_OP  = OFS_V + DIM_W;

   disp_state_t        state_q, state_d;
   logic [INSTR_W-1:0] fields_q, fields_d;
   logic               overflow_q, overflow_d;
   logic [INSTR_W-1:0] head;
   logic               fifo_full, fifo_empty, pop, head_is_nop;
   logic [CNT_W-1:0]   fifo_count;

   dispatch_fifo #(
      .DEPTH (DEPTH),
      .W     (INSTR_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (bus.write_i),
      .pop_i   (pop),
      .flush_i (bus.flush_i),
      .din_i   (bus.instruction_i),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign head_is_nop = (head[OFS_OP +: OP_W] == '0);

   // Handshake: start_o pulses for one cycle in ISSUE with fields valid; the instruction stays in
   // flight until done_i is seen in BUSY. done_i outside BUSY is ignored.
   always_comb begin
      state_d    = state_q;
      fields_d   = fields_q;
      pop        = 1'b0;
      overflow_d = overflow_q | (bus.write_i & fifo_full);
      case (state_q)
         IDLE:  pop = !fifo_empty && !bus.flush_i;
         ISSUE: state_d = BUSY;
         BUSY: begin
            if (bus.done_i) begin
               pop     = !fifo_empty && !bus.flush_i;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A popped NOP retires in place; anything else is latched and issued.
      if (pop && !head_is_nop) begin
         state_d  = ISSUE;
         fields_d = head;
      end else if (pop) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         fields_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         fields_q   <= fields_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.start_o            = (state_q == ISSUE);
   assign bus.busy_o             = (state_q != IDLE);
   assign bus.idle_o             = fifo_empty && (state_q == IDLE);
   assign bus.iq_full_o          = fifo_full;
   assign bus.count_o            = fifo_count;
   assign bus.overflow_o         = overflow_q;
   assign bus.state_o            = state_q;
   assign bus.MAC_op_o           = fields_q[OFS_OP  +: OP_W];
   assign bus.V_dim_o            = fields_q[OFS_V   +: DIM_W];
   assign bus.U_dim_o            = fields_q[OFS_U   +: DIM_W];
   assign bus.ITER_dim_o         = fields_q[OFS_IT  +: DIM_W];
   assign bus.V_dim1_o           = fields_q[OFS_V1  +: DIM_W];
   assign bus.U_dim1_o           = fields_q[OFS_U1  +: DIM_W];
   assign bus.ITER_dim1_o        = fields_q[OFS_IT1 +: DIM_W];
   assign bus.ub_addr_start_rd_o = fields_q[OFS_RD  +: ADDR_W];
   assign bus.ub_addr_start_wr_o = fields_q[OFS_WR  +: ADDR_W];

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Self-checking bench for instruction_dispatcher: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a queue-based behavioural model.
module tb_instruction_dispatcher;
   import instruction_dispatcher_pkg::*;

   localparam int DEPTH = 8;
   localparam int W     = DISP_INSTR_W;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   instruction_dispatcher_if #(.DEPTH(DEPTH)) bus();

   instruction_dispatcher #(.DEPTH(DEPTH)) dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // The queue holds accepted, not yet popped instructions; in-flight is tracked as
   // "issued and not finished" plus whether this is its first (start) cycle.
   logic [W-1:0]  exp_q[$];
   instr_fields_t m_fields;
   bit            m_start, m_busy, m_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         m_fields = '0;
         m_start  = 1'b0;
         m_busy   = 1'b0;
         m_ovf    = 1'b0;
      end else begin
         bit            was_full, can_pop;
         instr_fields_t x;
         was_full = (exp_q.size() == DEPTH);
         if (bus.write_i && was_full) m_ovf = 1'b1;
         can_pop = !bus.flush_i && (exp_q.size() != 0) &&
                   (!m_busy || (!m_start && bus.done_i));
         if (can_pop) begin
            x = exp_q.pop_front();
            if (x.op != OP_NOP) begin
               m_fields = x;
               m_start  = 1'b1;
               m_busy   = 1'b1;
            end else begin
               m_start = 1'b0;
               m_busy  = 1'b0;
            end
         end else if (m_start) begin
            m_start = 1'b0;
         end else if (m_busy && bus.done_i) begin
            m_busy = 1'b0;
         end
         if (bus.flush_i) exp_q.delete();
         else if (bus.write_i && !was_full) exp_q.push_back(bus.instruction_i);
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         check("count",    bus.count_o, exp_q.size());
         check("full",     bus.iq_full_o, exp_q.size() == DEPTH);
         check("overflow", bus.overflow_o, m_ovf);
         check("start",    bus.start_o, m_start);
         check("busy",     bus.busy_o, m_busy);
         check("idle",     bus.idle_o, (exp_q.size() == 0) && !m_busy);
         check("fields",   {bus.MAC_op_o, bus.V_dim_o, bus.U_dim_o, bus.ITER_dim_o,
                            bus.V_dim1_o, bus.U_dim1_o, bus.ITER_dim1_o,
                            bus.ub_addr_start_rd_o, bus.ub_addr_start_wr_o}, m_fields);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] instr);
      bus.instruction_i = instr;
      bus.write_i       = 1'b1;
      tick();
      bus.write_i       = 1'b0;
   endtask

   function automatic logic [W-1:0] rand_instr(input logic [DISP_OP_W-1:0] op);
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return {op, r[W-DISP_OP_W-1:0]};
   endfunction

   task automatic reset_dut();
      #2 rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      bus.done_i = 1'b1;
      while (!bus.idle_o && n < 100) begin
         tick();
         n++;
      end
      bus.done_i = 1'b0;
      check({name, "_drained"}, bus.idle_o, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      instr_fields_t f;
      bus.instruction_i = '0;
      bus.write_i       = 1'b0;
      bus.flush_i       = 1'b0;
      bus.done_i        = 1'b0;

      reset_dut();
      cmp_en = 1'b1;
      check("rst_idle",  bus.idle_o, 1'b1);
      check("rst_count", bus.count_o, 0);
      check("rst_op",    bus.MAC_op_o, 0);

      // 1: single instruction latency and completion
      f = '0;
      f.op = 3'd1; f.v_dim = 7'd4; f.u_dim = 7'd2; f.iter_dim = 7'd3; f.addr_rd = 12'h010;
      push(f);
      check("t1_no_start_t1", bus.start_o, 1'b0);
      tick();
      check("t1_start", bus.start_o, 1'b1);
      check("t1_op",    bus.MAC_op_o, 3'd1);
      check("t1_v",     bus.V_dim_o, 7'd4);
      check("t1_u",     bus.U_dim_o, 7'd2);
      check("t1_iter",  bus.ITER_dim_o, 7'd3);
      check("t1_rd",    bus.ub_addr_start_rd_o, 12'h010);
      check("t1_busy",  bus.busy_o, 1'b1);
      repeat (4) tick();
      check("t1_still_busy", bus.busy_o, 1'b1);
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      check("t1_idle", bus.idle_o, 1'b1);

      // 2: fill to full behind an in-flight instruction, then overflow
      push(rand_instr(3'd1));
      tick();
      for (int i = 0; i < DEPTH; i++) push(rand_instr(3'($urandom_range(1, 7))));
      check("t2_full",  bus.iq_full_o, 1'b1);
      check("t2_count", bus.count_o, DEPTH);
      push(rand_instr(3'd5));
      check("t2_ovf",        bus.overflow_o, 1'b1);
      check("t2_count_drop", bus.count_o, DEPTH);
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      check("t2_count_pop", bus.count_o, DEPTH - 1);
      check("t2_bb_start",  bus.start_o, 1'b1);
      drain("t2");
      check("t2_ovf_sticky", bus.overflow_o, 1'b1);

      // 3: back-to-back dispatch
      push(rand_instr(3'd1));
      push(rand_instr(3'd2));
      check("t3_a_start", bus.start_o, 1'b1);
      check("t3_a_op",    bus.MAC_op_o, 3'd1);
      repeat (3) tick();
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      check("t3_b_start", bus.start_o, 1'b1);
      check("t3_b_op",    bus.MAC_op_o, 3'd2);
      check("t3_b_busy",  bus.busy_o, 1'b1);
      drain("t3");

      // 4: NOPs retire silently ahead of C
      push(rand_instr(3'd0));
      push(rand_instr(3'd0));
      push(rand_instr(3'd3));
      check("t4_no_start", bus.start_o, 1'b0);
      check("t4_op_held",  bus.MAC_op_o, 3'd2);
      tick();
      check("t4_c_start", bus.start_o, 1'b1);
      check("t4_c_op",    bus.MAC_op_o, 3'd3);
      drain("t4");

      // 5: flush with a concurrent write while A is busy
      for (int i = 0; i < 4; i++) push(rand_instr(3'($urandom_range(1, 7))));
      check("t5_count3", bus.count_o, 3);
      check("t5_busy",   bus.busy_o, 1'b1);
      bus.flush_i = 1'b1;
      push(rand_instr(3'd6));
      bus.flush_i = 1'b0;
      check("t5_flushed", bus.count_o, 0);
      check("t5_a_busy",  bus.busy_o, 1'b1);
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      check("t5_idle", bus.idle_o, 1'b1);

      // 6: asynchronous reset mid-BUSY
      for (int i = 0; i < 5; i++) push(rand_instr(3'($urandom_range(1, 7))));
      check("t6_count4", bus.count_o, 4);
      #3 rst_n = 1'b0;
      #1;
      check("t6_count", bus.count_o, 0);
      check("t6_busy",  bus.busy_o, 1'b0);
      check("t6_idle",  bus.idle_o, 1'b1);
      check("t6_ovf",   bus.overflow_o, 1'b0);
      check("t6_start", bus.start_o, 1'b0);
      check("t6_op",    bus.MAC_op_o, 0);
      tick();
      rst_n = 1'b1;
      bus.done_i = 1'b1;
      tick();
      bus.done_i = 1'b0;
      check("t6_done_ignored", bus.idle_o, 1'b1);
      check("t6_no_start",     bus.start_o, 1'b0);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bus.write_i       = ($urandom_range(0, 99) < 45);
         bus.instruction_i = rand_instr(3'($urandom_range(0, 7)));
         bus.done_i        = ($urandom_range(0, 99) < 30);
         bus.flush_i       = ($urandom_range(0, 99) < 3);
         tick();
      end
      bus.write_i = 1'b0;
      bus.flush_i = 1'b0;
      drain("rand");

      tick();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
